// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU op codes, RV32I opcode constants and funct3 mapping
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_SLT  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  // alt selects SUB/SRA for the funct3 codes that have an alternate form
  function automatic alu_op_t f3_to_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I integer-ALU decode to op and operands
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output alu_op_t     alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  rd_addr,
  output logic        reg_write,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;
  logic        legal;
  alu_op_t     op_raw;
  logic [31:0] a_raw;
  logic [31:0] b_raw;

  assign opcode  = instr[6:0];
  assign funct3  = instr[14:12];
  assign funct7  = instr[31:25];
  assign imm_i   = {{20{instr[31]}}, instr[31:20]};
  assign imm_u   = {instr[31:12], 12'b0};
  assign shamt   = {27'b0, instr[24:20]};
  assign rd_addr = instr[11:7];

  always_comb begin
    legal  = 1'b0;
    op_raw = ALU_ADD;
    a_raw  = 32'b0;
    b_raw  = 32'b0;
    case (opcode)
      OP_R: begin
        a_raw = rs1_data;
        b_raw = rs2_data;
        if (funct7 == FUNCT7_BASE) begin
          legal  = 1'b1;
          op_raw = f3_to_op(funct3, 1'b0);
        end else if (funct7 == FUNCT7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
          legal  = 1'b1;
          op_raw = f3_to_op(funct3, 1'b1);
        end
      end
      OP_IMM: begin
        a_raw = rs1_data;
        case (funct3)
          3'b001: begin
            b_raw  = shamt;
            legal  = (funct7 == FUNCT7_BASE);
            op_raw = ALU_SLL;
          end
          3'b101: begin
            b_raw  = shamt;
            legal  = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
            op_raw = f3_to_op(funct3, funct7[5]);
          end
          default: begin
            b_raw  = imm_i;
            legal  = 1'b1;
            op_raw = f3_to_op(funct3, 1'b0);
          end
        endcase
      end
      OP_LUI: begin
        legal = 1'b1;
        b_raw = imm_u;
      end
      OP_AUIPC: begin
        legal = 1'b1;
        a_raw = pc;
        b_raw = imm_u;
      end
      default: legal = 1'b0;
    endcase
  end

  // Illegal entries travel down the pipe as a harmless ADD 0,0
  assign alu_op    = legal ? op_raw : ALU_ADD;
  assign alu_a     = legal ? a_raw : 32'b0;
  assign alu_b     = legal ? b_raw : 32'b0;
  assign reg_write = legal && (rd_addr != 5'd0);
  assign illegal   = !legal;

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - valid/ready pipeline register feeding the ALU
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [4:0]      rd_addr,
  output logic            reg_write,
  output logic            illegal
);

  alu_op_t         dec_op;
  logic [XLEN-1:0] dec_a;
  logic [XLEN-1:0] dec_b;
  logic [4:0]      dec_rd;
  logic            dec_we;
  logic            dec_ill;

  alu_op_decode u_decode (
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .alu_op    (dec_op),
    .alu_a     (dec_a),
    .alu_b     (dec_b),
    .rd_addr   (dec_rd),
    .reg_write (dec_we),
    .illegal   (dec_ill)
  );

  logic            valid_q, valid_d;
  alu_op_t         op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] b_q;
  logic [4:0]      rd_q;
  logic            we_q;
  logic            ill_q;
  logic            accept;

  assign in_ready = !flush && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush wins; an accept refills the slot even while it is being consumed
  always_comb begin
    valid_d = valid_q;
    if (flush)          valid_d = 1'b0;
    else if (accept)    valid_d = 1'b1;
    else if (out_ready) valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      valid_q <= 1'b0;
      op_q    <= ALU_AND;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= 5'd0;
      we_q    <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        op_q  <= dec_op;
        a_q   <= dec_a;
        b_q   <= dec_b;
        rd_q  <= dec_rd;
        we_q  <= dec_we;
        ill_q <= dec_ill;
      end
    end
  end

  assign out_valid = valid_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign rd_addr   = rd_q;
  assign reg_write = we_q;
  assign illegal   = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

  logic        clk;
  logic        n_rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rd_addr;
  logic        reg_write;
  logic        illegal;

  int passed;
  int total;

  alu_issue_stage #(.XLEN(32)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .pc        (pc),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .rd_addr   (rd_addr),
    .reg_write (reg_write),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic present(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    rs1_data = r1;
    rs2_data = r2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
    total++; if (alu_op !== 4'h0) $display("FAIL reset_op: got %h want 0", alu_op); else passed++;
    total++; if (alu_a !== 32'h0 || alu_b !== 32'h0) $display("FAIL reset_ab: got %h %h want 0 0", alu_a, alu_b); else passed++;
    total++; if (rd_addr !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0)
      $display("FAIL reset_rd_we_ill: got %0d %b %b want 0 0 0", rd_addr, reg_write, illegal); else passed++;
    @(posedge clk); #1;
    n_rst = 1'b1;
    #1;
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    present(32'h403100B3, 32'h0, 32'd10, 32'd3);
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL sub_in_ready: got %b want 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL sub_valid: got %b want 1", out_valid); else passed++;
    total++; if (alu_op !== 4'b0110) $display("FAIL sub_op: got %b want 0110", alu_op); else passed++;
    total++; if (alu_a !== 32'd10 || alu_b !== 32'd3) $display("FAIL sub_ab: got %0d %0d want 10 3", alu_a, alu_b); else passed++;
    total++; if (rd_addr !== 5'd1 || reg_write !== 1'b1 || illegal !== 1'b0)
      $display("FAIL sub_rd_we_ill: got %0d %b %b want 1 1 0", rd_addr, reg_write, illegal); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL sub_drain: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_srai_addi();
    out_ready = 1'b1;
    present(32'h40435293, 32'h0, 32'h8000_0000, 32'h0);
    tick();
    total++; if (alu_op !== 4'b0111 || alu_b !== 32'd4) $display("FAIL srai: got op %b b %h want 0111 4", alu_op, alu_b); else passed++;
    total++; if (alu_a !== 32'h8000_0000 || rd_addr !== 5'd5) $display("FAIL srai_a_rd: got %h %0d want 80000000 5", alu_a, rd_addr); else passed++;
    present(32'hFFF00093, 32'h0, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL addi_valid: got %b want 1", out_valid); else passed++;
    total++; if (alu_op !== 4'b0010 || alu_b !== 32'hFFFF_FFFF) $display("FAIL addi_neg: got op %b b %h want 0010 ffffffff", alu_op, alu_b); else passed++;
    tick();
  endtask

  task automatic test_lui_auipc();
    out_ready = 1'b1;
    present(32'h12345117, 32'h100, 32'hDEAD_BEEF, 32'h0);
    tick();
    total++; if (alu_op !== 4'b0010) $display("FAIL auipc_op: got %b want 0010", alu_op); else passed++;
    total++; if (alu_a !== 32'h100 || alu_b !== 32'h1234_5000) $display("FAIL auipc_ab: got %h %h want 100 12345000", alu_a, alu_b); else passed++;
    total++; if (rd_addr !== 5'd2 || reg_write !== 1'b1) $display("FAIL auipc_rd: got %0d %b want 2 1", rd_addr, reg_write); else passed++;
    present(32'hABCDE1B7, 32'h100, 32'hDEAD_BEEF, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (alu_op !== 4'b0010 || alu_a !== 32'h0 || alu_b !== 32'hABCD_E000)
      $display("FAIL lui: got op %b a %h b %h want 0010 0 abcde000", alu_op, alu_a, alu_b); else passed++;
    tick();
  endtask

  task automatic test_back_to_back_stall();
    out_ready = 1'b1;
    present(32'h403100B3, 32'h0, 32'd10, 32'd3);
    tick();
    out_ready = 1'b0;
    present(32'h0062C233, 32'h0, 32'h0000_00F0, 32'h0000_000F);
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready[%0d]: got %b want 0", c, in_ready); else passed++;
      tick();
      total++; if (out_valid !== 1'b1 || alu_op !== 4'b0110 || alu_a !== 32'd10 || alu_b !== 32'd3)
        $display("FAIL stall_hold[%0d]: got v %b op %b a %h b %h want 1 0110 a 3", c, out_valid, alu_op, alu_a, alu_b); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || alu_op !== 4'b0011 || alu_a !== 32'hF0 || alu_b !== 32'h0F || rd_addr !== 5'd4)
      $display("FAIL no_bubble: got v %b op %b a %h b %h rd %0d want 1 0011 f0 f 4", out_valid, alu_op, alu_a, alu_b, rd_addr); else passed++;
    tick();
  endtask

  task automatic test_illegal_rd0();
    out_ready = 1'b1;
    present(32'h0000000B, 32'h40, 32'h11, 32'h22);
    tick();
    total++; if (out_valid !== 1'b1 || illegal !== 1'b1 || reg_write !== 1'b0)
      $display("FAIL illegal_opc: got v %b ill %b we %b want 1 1 0", out_valid, illegal, reg_write); else passed++;
    total++; if (alu_op !== 4'b0010 || alu_a !== 32'h0 || alu_b !== 32'h0)
      $display("FAIL illegal_data: got op %b a %h b %h want 0010 0 0", alu_op, alu_a, alu_b); else passed++;
    present(32'h00208033, 32'h0, 32'd5, 32'd7);
    tick();
    total++; if (illegal !== 1'b0 || reg_write !== 1'b0) $display("FAIL add_x0: got ill %b we %b want 0 0", illegal, reg_write); else passed++;
    total++; if (alu_op !== 4'b0010 || alu_a !== 32'd5 || alu_b !== 32'd7)
      $display("FAIL add_x0_data: got op %b a %h b %h want 0010 5 7", alu_op, alu_a, alu_b); else passed++;
    present(32'h4020C0B3, 32'h0, 32'd5, 32'd7);
    tick();
    total++; if (illegal !== 1'b1 || reg_write !== 1'b0) $display("FAIL alt_xor: got ill %b we %b want 1 0", illegal, reg_write); else passed++;
    present(32'h40209093, 32'h0, 32'd5, 32'd7);
    tick();
    in_valid = 1'b0;
    total++; if (illegal !== 1'b1 || alu_b !== 32'h0) $display("FAIL slli_alt: got ill %b b %h want 1 0", illegal, alu_b); else passed++;
    tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    present(32'h403100B3, 32'h0, 32'd10, 32'd3);
    flush = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_drop: got %b want 0", out_valid); else passed++;
    flush = 1'b0;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL flush_reload: got %b want 1", out_valid); else passed++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL flush_held: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid_stall();
    out_ready = 1'b0;
    present(32'h12345117, 32'h100, 32'h0, 32'h0);
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL pre_reset_valid: got %b want 1", out_valid); else passed++;
    #2;
    n_rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || alu_op !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0)
      $display("FAIL async_reset: got v %b op %h a %h b %h want 0 0 0 0", out_valid, alu_op, alu_a, alu_b); else passed++;
    total++; if (rd_addr !== 5'd0 || reg_write !== 1'b0 || illegal !== 1'b0)
      $display("FAIL async_reset_rd: got %0d %b %b want 0 0 0", rd_addr, reg_write, illegal); else passed++;
    tick();
    n_rst = 1'b1;
  endtask

  initial begin
    passed    = 0;
    total     = 0;
    n_rst     = 1'b0;
    in_valid  = 1'b0;
    instr     = 32'h0;
    pc        = 32'h0;
    rs1_data  = 32'h0;
    rs2_data  = 32'h0;
    flush     = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_sub();
    test_srai_addi();
    test_lui_auipc();
    test_back_to_back_stall();
    test_illegal_rd0();
    test_flush();
    test_reset_mid_stall();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Decode-to-execute issue register that produces the 4-bit ALU operation code and both ALU operands from a fetched RV32I instruction. It sits between register-file read and the ALU, and drives the ALU's operation, first-operand and second-operand inputs from a registered, valid/ready-handshaked pipeline slot. It decodes the integer-ALU subset only: R-type, I-type ALU, LUI and AUIPC. Everything else is flagged illegal.

## Interface
Parameters:
- `XLEN`, default 32: datapath width. Only 32 is supported.

Ports:
- `clk`, input, 1: rising-edge clock.
- `n_rst`, input, 1: asynchronous, active-low reset.
- `in_valid`, input, 1: upstream presents an instruction.
- `in_ready`, output, 1: stage accepts the instruction this cycle.
- `instr`, input, 32: instruction word.
- `pc`, input, 32: instruction address.
- `rs1_data`, input, 32: register-file read of rs1.
- `rs2_data`, input, 32: register-file read of rs2.
- `flush`, input, 1: kill the held entry and any entry being accepted.
- `out_valid`, output, 1: registered entry is valid.
- `out_ready`, input, 1: downstream consumes the entry.
- `alu_op`, output, 4: ALU operation code.
- `alu_a`, output, 32: first ALU operand.
- `alu_b`, output, 32: second ALU operand.
- `rd_addr`, output, 5: destination register.
- `reg_write`, output, 1: result is to be written back.
- `illegal`, output, 1: instruction is not in the supported subset.

## Operation
- **Op codes:**
  - ADD = 0010, SUB = 0110, AND = 0000, OR = 0001, XOR = 0011.
  - SLL = 0100, SRL = 0101, SRA = 0111, SLT = 1000, SLTU = 1001.
- **R-type (opcode 0110011):**
  - funct3 maps as 000 → ADD/SUB, 001 → SLL, 010 → SLT, 011 → SLTU, 100 → XOR, 101 → SRL/SRA, 110 → OR, 111 → AND.
  - funct7 = 0100000 selects SUB (with funct3 000) or SRA (with funct3 101).
  - funct7 = 0100000 with any other funct3 is illegal. Any funct7 other than 0000000 or 0100000 is illegal.
  - Operands: a = rs1_data, b = rs2_data.
- **I-type ALU (opcode 0010011):**
  - funct3 is mapped as for R-type, except 000 is always ADD.
  - b = sign-extended imm[11:0].
  - Shifts (funct3 001 and 101): b = {27'b0, shamt}.
  - SLLI requires funct7 = 0000000. SRLI/SRAI require funct7 = 0000000 or 0100000. Anything else is illegal.
- **LUI (opcode 0110111):** op ADD, a = 0, b = {imm[31:12], 12'b0}.
- **AUIPC (opcode 0010111):** op ADD, a = pc, b = {imm[31:12], 12'b0}.
- **Illegal instructions:** any other opcode, or any illegal funct combination above. The entry is captured with alu_op = ADD, a = 0, b = 0, reg_write = 0, illegal = 1.
- **Writeback enable:** reg_write = legal and (rd ≠ 0).

## Timing
- **Latency:** 1 cycle. An instruction accepted at edge N appears on the outputs after edge N, and out_valid is 1 in cycle N+1.
- **Ready:** in_ready = !flush && (!out_valid || out_ready). This is combinational; there is no skid buffer.
- **Transfers:**
  - Accept occurs on in_valid && in_ready.
  - Consume occurs on out_valid && out_ready.
  - Simultaneous consume and accept replaces the entry with no bubble.
- **Stall:** while out_valid && !out_ready, all outputs hold stable.
- **Flush:** takes priority over everything. out_valid is 0 at the next edge, and a simultaneously presented instruction is dropped.
- **Reset:** n_rst low clears the outputs immediately, without waiting for a clock edge:
  - out_valid = 0, alu_op = 0000, alu_a = 0, alu_b = 0.
  - rd_addr = 0, reg_write = 0, illegal = 0.
  - This applies mid-stall as well.
- **Output gating:** data outputs are don't-care when out_valid = 0. The verifier checks them only when out_valid = 1.

## Structure
- **Package `alu_pkg`:**
  - The 4-bit op-code constants above, as a typedef'd enum `alu_op_t`.
  - Opcode constants: OP_R = 0110011, OP_IMM = 0010011, OP_LUI = 0110111, OP_AUIPC = 0010111.
  - Shared by the ALU and this stage.
- **Sub-module `alu_op_decode`:** purely combinational, maps instr/pc/rs data to op, a, b, rd, reg_write and illegal. The top level holds only the handshake and the pipeline register.

## Test plan
- **R-type SUB:** sub x1,x2,x3 (0x403100B3), rs1_data = 10, rs2_data = 3 → next cycle alu_op = 0110, a = 10, b = 3, rd_addr = 1, reg_write = 1.
- **SRAI and negative ADDI:**
  - srai x5,x6,4 (0x40435293) → alu_op = 0111, b = 4.
  - addi x1,x0,-1 (0xFFF00093) → alu_op = 0010, b = 0xFFFFFFFF.
- **LUI/AUIPC:** auipc x2,0x12345 (0x12345117) at pc = 0x100 → alu_op = 0010, a = 0x100, b = 0x12345000.
- **Backpressure:**
  - Hold out_ready = 0 for 3 cycles with the next instruction presented → in_ready = 0, outputs unchanged.
  - The cycle out_ready = 1 → the new entry is captured with no bubble.
- **Illegal and rd = x0:**
  - 0x0000000B → illegal = 1, reg_write = 0.
  - add x0,x1,x2 (0x00208033) → illegal = 0, reg_write = 0.
- **Flush and reset:**
  - flush = 1 together with in_valid = 1 → out_valid = 0 next cycle and the instruction is dropped.
  - n_rst asserted mid-stall → out_valid = 0 immediately and all outputs are 0.
